// File: rtl/mcu_spi_link_pkg.sv
// Shared definitions for the MCU SPI link: target ids, target count and the
// filler byte returned when a frame addresses a target that does not exist.
package mcu_spi_link_pkg;

  typedef enum logic [1:0] {
    TGT_SYS = 2'd0,
    TGT_HID = 2'd1,
    TGT_OSD = 2'd2,
    TGT_SDC = 2'd3
  } tgt_id_e;

  localparam int          NUM_TGT      = 4;
  localparam logic [7:0]  RESP_INVALID = 8'hFF;
  localparam logic [7:0]  BYTE_CNT_MAX = 8'd255;

  function automatic logic [NUM_TGT-1:0] tgt_onehot(input tgt_id_e id);
    logic [NUM_TGT-1:0] oh;
    case (id)
      TGT_SYS: oh = 4'b0001;
      TGT_HID: oh = 4'b0010;
      TGT_OSD: oh = 4'b0100;
      TGT_SDC: oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI line, plus a history flop
// that yields single-clk rise/fall pulses of the synchronized level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // synchronizer chain and previous-level flop
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/mcu_spi_link.sv
// SPI mode-0 slave linking the MCU to four on-chip targets: byte 0 selects a
// target, later bytes are strobed to it, and its response bytes shift back out.
module mcu_spi_link
  import mcu_spi_link_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_ss_n_i,
  input  logic                 spi_sck_i,
  input  logic                 spi_mosi_i,
  output logic                 spi_miso_o,
  output logic [NUM_TGT-1:0]   tgt_strobe_o,
  output logic [NUM_TGT-1:0]   tgt_start_o,
  output logic [7:0]           tgt_din_o,
  input  logic [8*NUM_TGT-1:0] tgt_dout_i,
  input  logic [NUM_TGT-1:0]   tgt_irq_i,
  output logic                 mcu_irq_n_o
);

  logic ss_s, ss_fall_s, ss_rise_unused_s;
  logic sck_rise_s, sck_fall_s, sck_lvl_unused_s;
  logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .d_i(spi_ss_n_i),
    .q_o(ss_s), .rise_o(ss_rise_unused_s), .fall_o(ss_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .d_i(spi_sck_i),
    .q_o(sck_lvl_unused_s), .rise_o(sck_rise_s), .fall_o(sck_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d_i(spi_mosi_i),
    .q_o(mosi_s), .rise_o(mosi_rise_unused_s), .fall_o(mosi_fall_unused_s)
  );

  logic [1:0]         settle_q, settle_d;
  logic               armed_q, armed_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         rx_q, rx_d;
  logic               byte_done_q, byte_done_d;
  logic [7:0]         byte_cnt_q, byte_cnt_d;
  tgt_id_e            tgt_sel_q, tgt_sel_d;
  logic               bad_q, bad_d;
  logic               load_q, load_d;
  logic [7:0]         tx_q, tx_d;
  logic [NUM_TGT-1:0] strobe_q, strobe_d;
  logic [NUM_TGT-1:0] start_q, start_d;
  logic [7:0]         din_q, din_d;
  logic               irq_n_q, irq_n_d;
  logic               active_s, frame_start_s;

  // next-state logic for the receive path, frame decode and response shifter
  always_comb begin
    // After reset, a frame may only begin once ss_n has been seen high
    // through a settled synchronizer, so a select held low across reset is ignored.
    settle_d      = (settle_q == 2'd3) ? 2'd3 : settle_q + 2'd1;
    armed_d       = armed_q | ((settle_q == 2'd3) & ss_s);
    active_s      = armed_q & ~ss_s;
    frame_start_s = armed_q & ss_fall_s;

    rx_d        = rx_q;
    byte_done_d = 1'b0;
    if (!active_s) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise_s) begin
      rx_d        = {rx_q[6:0], mosi_s};
      bit_cnt_d   = bit_cnt_q + 3'd1;
      byte_done_d = (bit_cnt_q == 3'd7);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    // byte_done is honoured even if ss_n rose in the same clk
    strobe_d  = {NUM_TGT{1'b0}};
    start_d   = {NUM_TGT{1'b0}};
    din_d     = din_q;
    tgt_sel_d = tgt_sel_q;
    bad_d     = bad_q;
    if (byte_done_q && (byte_cnt_q == 8'd0)) begin
      tgt_sel_d = tgt_id_e'(rx_q[1:0]);
      bad_d     = |rx_q[7:2];
    end else if (byte_done_q && !bad_q) begin
      strobe_d = tgt_onehot(tgt_sel_q);
      start_d  = (byte_cnt_q == 8'd1) ? tgt_onehot(tgt_sel_q) : {NUM_TGT{1'b0}};
      din_d    = rx_q;
    end else begin
      strobe_d = {NUM_TGT{1'b0}};
    end

    if (!active_s) begin
      byte_cnt_d = 8'd0;
    end else if (byte_done_q && (byte_cnt_q != BYTE_CNT_MAX)) begin
      byte_cnt_d = byte_cnt_q + 8'd1;
    end else begin
      byte_cnt_d = byte_cnt_q;
    end

    // load_q trails byte_done by one clk so tgt_sel already reflects byte 0
    load_d = byte_done_q;
    if (frame_start_s) begin
      tx_d = {4'h0, tgt_irq_i};
    end else if (load_q) begin
      tx_d = bad_q ? RESP_INVALID : tgt_dout_i[{tgt_sel_q, 3'b000} +: 8];
    end else if (active_s && sck_fall_s && (bit_cnt_q != 3'd0)) begin
      tx_d = {tx_q[6:0], 1'b1};
    end else begin
      tx_d = tx_q;
    end

    irq_n_d = ~|tgt_irq_i;
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      byte_done_q <= 1'b0;
      byte_cnt_q  <= 8'd0;
      tgt_sel_q   <= TGT_SYS;
      bad_q       <= 1'b0;
      load_q      <= 1'b0;
      tx_q        <= 8'hFF;
      strobe_q    <= {NUM_TGT{1'b0}};
      start_q     <= {NUM_TGT{1'b0}};
      din_q       <= 8'h00;
      irq_n_q     <= 1'b1;
    end else begin
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      byte_done_q <= byte_done_d;
      byte_cnt_q  <= byte_cnt_d;
      tgt_sel_q   <= tgt_sel_d;
      bad_q       <= bad_d;
      load_q      <= load_d;
      tx_q        <= tx_d;
      strobe_q    <= strobe_d;
      start_q     <= start_d;
      din_q       <= din_d;
      irq_n_q     <= irq_n_d;
    end
  end

  assign spi_miso_o   = tx_q[7];
  assign tgt_strobe_o = strobe_q;
  assign tgt_start_o  = start_q;
  assign tgt_din_o    = din_q;
  assign mcu_irq_n_o  = irq_n_q;

endmodule

// File: tb/tb_mcu_spi_link.sv
// Bench for mcu_spi_link: an SPI master drives frames, strobes are captured,
// and both are compared with a frame-level model of the link.
module tb_mcu_spi_link;

  logic        clk = 1'b0;
  logic        reset;
  logic        ss_n, sck, mosi, miso;
  logic [3:0]  strobe, start;
  logic [7:0]  din;
  logic [31:0] dout;
  logic [3:0]  irq;
  logic        irq_n;

  int checks = 0;
  int failures = 0;
  int multihot = 0;

  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  tx_bytes[0:299];
  logic [7:0]  rx_bytes[0:299];
  logic [31:0] dout_tab[0:299];
  logic [3:0]  frame_irq;

  mcu_spi_link dut (
    .clk(clk), .reset(reset),
    .spi_ss_n_i(ss_n), .spi_sck_i(sck), .spi_mosi_i(mosi), .spi_miso_o(miso),
    .tgt_strobe_o(strobe), .tgt_start_o(start), .tgt_din_o(din),
    .tgt_dout_i(dout), .tgt_irq_i(irq), .mcu_irq_n_o(irq_n)
  );

  always #5 clk = ~clk;

  // capture every strobe as {strobe, start, din}
  always @(negedge clk) begin
    if (strobe != 4'b0000) begin
      obs_q.push_back({strobe, start, din});
      if ($countones(strobe) > 1) multihot++;
    end
  end

  // frame-level model: byte 0 picks the target, every later byte goes to it
  function automatic void build_exp(input int n);
    logic [3:0] oh;
    exp_q.delete();
    if (tx_bytes[0] < 8'd4) begin
      oh = 4'b0001 << tx_bytes[0][1:0];
      for (int k = 1; k < n; k++)
        exp_q.push_back({oh, (k == 1) ? oh : 4'b0000, tx_bytes[k]});
    end
  endfunction

  // MISO during byte k: status at frame start, then the reply to byte k-1
  function automatic logic [7:0] exp_miso(input int k);
    logic [31:0] d;
    if (k == 0) return {4'h0, frame_irq};
    if (tx_bytes[0] >= 8'd4) return 8'hFF;
    d = dout_tab[k-1] >> (8 * int'(tx_bytes[0]));
    return d[7:0];
  endfunction

  task automatic send_bit(input logic b, input int h, output logic r);
    mosi = b;
    repeat (h) @(negedge clk);
    sck = 1'b1;
    r = miso;
    repeat (h) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nb, input int h, output logic [7:0] r);
    logic bt;
    r = 8'h00;
    for (int i = 0; i < nb; i++) begin
      send_bit(b[7-i], h, bt);
      r[7-i] = bt;
    end
  endtask

  task automatic run_frame(input int n, input int h);
    logic [7:0] rb;
    obs_q.delete();
    frame_irq = irq;
    ss_n = 1'b0;
    repeat (2*h) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      dout = dout_tab[k];
      send_bits(tx_bytes[k], 8, h, rb);
      rx_bytes[k] = rb;
    end
    repeat (2*h) @(negedge clk);
    ss_n = 1'b1;
    repeat (4*h) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0; irq = 4'h0; dout = 32'h0;
    repeat (4) @(negedge clk);
    checks++; if (strobe !== 4'b0) begin failures++; $display("FAIL reset_strobe got=%h exp=0", strobe); end
    checks++; if (start !== 4'b0) begin failures++; $display("FAIL reset_start got=%h exp=0", start); end
    checks++; if (din !== 8'h00) begin failures++; $display("FAIL reset_din got=%h exp=00", din); end
    checks++; if (miso !== 1'b1) begin failures++; $display("FAIL reset_miso got=%b exp=1", miso); end
    checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL reset_irq_n got=%b exp=1", irq_n); end
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (miso !== 1'b1) begin failures++; $display("FAIL idle_miso got=%b exp=1", miso); end
  endtask

  task automatic test_cmd_frame();
    tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h01; tx_bytes[2] = 8'h2A;
    for (int k = 0; k < 3; k++) dout_tab[k] = 32'h3322_1100 + 32'h0404_0404 * k;
    run_frame(3, 8);
    build_exp(3);
    checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL cmd_count got=%0d exp=2", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL cmd_strobe[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (rx_bytes[k] !== exp_miso(k)) begin failures++; $display("FAIL cmd_miso[%0d] got=%h exp=%h", k, rx_bytes[k], exp_miso(k)); end
    end
  endtask

  task automatic test_irq_status();
    irq = 4'b0101;
    for (int i = 0; i < 3 && irq_n !== 1'b0; i++) @(negedge clk);
    checks++; if (irq_n !== 1'b0) begin failures++; $display("FAIL irq_assert got=%b exp=0", irq_n); end
    tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h10;
    dout_tab[0] = 32'h00AB_0000; dout_tab[1] = 32'h00CD_0000;
    run_frame(2, 8);
    checks++; if (rx_bytes[0] !== 8'h05) begin failures++; $display("FAIL irq_status got=%h exp=05", rx_bytes[0]); end
    checks++; if (rx_bytes[1] !== 8'hAB) begin failures++; $display("FAIL irq_resp got=%h exp=ab", rx_bytes[1]); end
    irq = 4'b0000;
    repeat (3) @(negedge clk);
    checks++; if (irq_n !== 1'b1) begin failures++; $display("FAIL irq_release got=%b exp=1", irq_n); end
  endtask

  task automatic test_resp_pipeline();
    for (int k = 0; k < 4; k++) tx_bytes[k] = 8'h00;
    dout_tab[0] = 32'h1111_11A7; dout_tab[1] = 32'h2222_225C;
    dout_tab[2] = 32'h3333_3342; dout_tab[3] = 32'h4444_4499;
    run_frame(4, 8);
    checks++; if (rx_bytes[1] !== 8'hA7) begin failures++; $display("FAIL pipe_miso1 got=%h exp=a7", rx_bytes[1]); end
    checks++; if (rx_bytes[2] !== 8'h5C) begin failures++; $display("FAIL pipe_miso2 got=%h exp=5c", rx_bytes[2]); end
    checks++; if (rx_bytes[3] !== 8'h42) begin failures++; $display("FAIL pipe_miso3 got=%h exp=42", rx_bytes[3]); end
    checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL pipe_count got=%0d exp=3", obs_q.size()); end
  endtask

  task automatic test_invalid();
    tx_bytes[0] = 8'h07; tx_bytes[1] = 8'h01; tx_bytes[2] = 8'h02;
    for (int k = 0; k < 3; k++) dout_tab[k] = 32'h1234_5678;
    run_frame(3, 8);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL inv_count got=%0d exp=0", obs_q.size()); end
    checks++; if (rx_bytes[1] !== 8'hFF) begin failures++; $display("FAIL inv_miso1 got=%h exp=ff", rx_bytes[1]); end
    checks++; if (rx_bytes[2] !== 8'hFF) begin failures++; $display("FAIL inv_miso2 got=%h exp=ff", rx_bytes[2]); end
  endtask

  task automatic test_abort();
    logic [7:0] rb;
    obs_q.delete();
    ss_n = 1'b0;
    repeat (16) @(negedge clk);
    send_bits(8'h01, 8, 8, rb);
    send_bits(8'h03, 8, 8, rb);
    send_bits(8'hF0, 5, 8, rb);
    repeat (8) @(negedge clk);
    ss_n = 1'b1;
    repeat (32) @(negedge clk);
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL abort_count got=%0d exp=1", obs_q.size()); end
    tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h03;
    dout_tab[0] = 32'h0; dout_tab[1] = 32'h0;
    run_frame(2, 8);
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL abort_next_count got=%0d exp=1", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== 16'h2203) begin failures++; $display("FAIL abort_next_strobe got=%h exp=2203", obs_q[0]); end
    end
  endtask

  task automatic test_ss_same_clk();
    logic [7:0] rb;
    logic bt;
    obs_q.delete();
    ss_n = 1'b0;
    repeat (16) @(negedge clk);
    send_bits(8'h01, 8, 8, rb);
    send_bits(8'h5A, 7, 8, rb);
    mosi = 1'b0;
    repeat (8) @(negedge clk);
    sck = 1'b1;
    @(negedge clk);
    ss_n = 1'b1;
    repeat (7) @(negedge clk);
    sck = 1'b0;
    repeat (32) @(negedge clk);
    bt = (obs_q.size() == 1) && (obs_q[0] === 16'h225A);
    checks++; if (!bt) begin failures++; $display("FAIL ss_same_clk got_count=%0d exp=1 strobe 225a", obs_q.size()); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] rb;
    ss_n = 1'b0;
    repeat (16) @(negedge clk);
    send_bits(8'h01, 8, 8, rb);
    send_bits(8'h44, 3, 8, rb);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (strobe !== 4'b0 || start !== 4'b0) begin failures++; $display("FAIL rst_mid_strobe got=%h/%h exp=0/0", strobe, start); end
    checks++; if (din !== 8'h00) begin failures++; $display("FAIL rst_mid_din got=%h exp=00", din); end
    checks++; if (miso !== 1'b1 || irq_n !== 1'b1) begin failures++; $display("FAIL rst_mid_miso_irq got=%b%b exp=11", miso, irq_n); end
    reset = 1'b0;
    obs_q.delete();
    send_bits(8'h44, 5, 8, rb);
    send_bits(8'h77, 8, 8, rb);
    send_bits(8'h66, 8, 8, rb);
    repeat (16) @(negedge clk);
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rst_mid_nostrobe got=%0d exp=0", obs_q.size()); end
    ss_n = 1'b1;
    repeat (32) @(negedge clk);
    tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h09;
    dout_tab[0] = 32'h0; dout_tab[1] = 32'h0;
    run_frame(2, 8);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== 16'h4409) begin failures++; $display("FAIL rst_mid_fresh got_count=%0d exp=1 strobe 4409", obs_q.size()); end
  endtask

  task automatic test_saturation();
    int starts;
    tx_bytes[0] = 8'h03;
    for (int k = 1; k < 260; k++) tx_bytes[k] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 260; k++) dout_tab[k] = 32'h0;
    run_frame(260, 4);
    build_exp(260);
    starts = 0;
    foreach (obs_q[i]) if (obs_q[i][11:8] != 4'b0) starts++;
    checks++; if (obs_q.size() != 259) begin failures++; $display("FAIL sat_count got=%0d exp=259", obs_q.size()); end
    checks++; if (starts != 1) begin failures++; $display("FAIL sat_starts got=%0d exp=1", starts); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL sat_strobe[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 5);
      irq = 4'($urandom_range(0, 15));
      repeat (2) @(negedge clk);
      tx_bytes[0] = 8'($urandom_range(0, 5));
      for (int k = 1; k < n; k++) tx_bytes[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < n; k++) dout_tab[k] = $urandom;
      run_frame(n, 8);
      build_exp(n);
      checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", f, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd%0d_strobe[%0d] got=%h exp=%h", f, i, obs_q[i], exp_q[i]); end
      end
      for (int k = 0; k < n; k++) begin
        checks++; if (rx_bytes[k] !== exp_miso(k)) begin failures++; $display("FAIL rnd%0d_miso[%0d] got=%h exp=%h", f, k, rx_bytes[k], exp_miso(k)); end
      end
      checks++; if (irq_n !== (irq == 4'h0)) begin failures++; $display("FAIL rnd%0d_irq_n got=%b irq=%h", f, irq_n, irq); end
    end
    irq = 4'h0;
    checks++; if (multihot != 0) begin failures++; $display("FAIL onehot_strobe got=%0d exp=0 multi-hot clks", multihot); end
  endtask

  initial begin
    test_reset();
    test_cmd_frame();
    test_irq_status();
    test_resp_pipeline();
    test_invalid();
    test_abort();
    test_ss_same_clk();
    test_reset_midframe();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcu_spi_link.md
MCU_SPI_LINK -- requirements
Module: mcu_spi_link

Interface
REQ-001 clk  in  1  system clock; reset  in  1  synchronous, active-high.
REQ-002 spi_ss_n  in  1  MCU chip select, active-low, asynchronous to clk.
REQ-003 spi_sck  in  1  MCU SPI clock, mode 0, MSB first, asynchronous; f(clk) >= 8 x f(sck).
REQ-004 spi_mosi  in  1  MCU to FPGA serial data.
REQ-005 spi_miso  out  1  FPGA to MCU serial data.
REQ-006 tgt_strobe  out  4  one-clk byte-valid pulse per target (0 sys, 1 hid, 2 osd, 3 sdc).
REQ-007 tgt_start  out  4  asserted with tgt_strobe only on the command byte of a frame.
REQ-008 tgt_din  out  8  received byte, shared by all targets, valid while any tgt_strobe is high.
REQ-009 tgt_dout  in  32  response bytes; bits [8t+7:8t] belong to target t.
REQ-010 tgt_irq  in  4  level interrupt requests, one per target.
REQ-011 mcu_irq_n  out  1  active-low OR of tgt_irq, registered.

Function
REQ-012 spi_ss_n, spi_sck, spi_mosi SHALL each pass a 2-flop synchronizer; edges SHALL be detected from synchronized sck (rise = 0 then 1, fall = 1 then 0).
REQ-013 While synchronized ss_n is high: bit_cnt = 0, byte_cnt = 0, no strobes, spi_miso driven from tx_sreg[7].
REQ-014 On each sck rise with ss_n low: rx_sreg <= {rx_sreg[6:0], mosi}; bit_cnt increments mod 8.
REQ-015 Byte complete when bit_cnt wraps 7 to 0; a byte_done pulse SHALL follow the completing rise by exactly 1 clk.
REQ-016 Frame byte 0 = target id: latched into tgt_sel; no strobe issued.
REQ-017 Frame byte 1 = command: tgt_strobe[tgt_sel] and tgt_start[tgt_sel] high for 1 clk, tgt_din = byte.
REQ-018 Frame bytes >= 2: tgt_strobe[tgt_sel] high for 1 clk, tgt_start low.
REQ-019 tgt_sel >= 4 SHALL mark the frame invalid: no strobes for the rest of the frame, response bytes 0xFF.
REQ-020 byte_cnt SHALL saturate at 255; saturation SHALL NOT stop strobes.
REQ-021 On ss_n falling (frame start), tx_sreg SHALL load {4'h0, tgt_irq} (status byte returned during byte 0).
REQ-022 Two clk after each byte_done, tx_sreg SHALL load tgt_dout byte of tgt_sel (0xFF if invalid); for byte 0 the target is the just-latched id.
REQ-023 On sck fall with ss_n low and bit_cnt != 0, tx_sreg shifts left with 1 filled; the fall following the 8th rise SHALL NOT shift.
REQ-024 spi_miso = tx_sreg[7] at all times; response to byte n appears during byte n+1.
REQ-025 ss_n rising mid-byte: partial byte discarded, no strobe, counters cleared next clk.
REQ-026 ss_n rising in the same clk as byte_done: strobe for that byte SHALL still be issued.
REQ-027 At most one bit of tgt_strobe SHALL be high in any clk.

Reset
REQ-028 On reset: tgt_strobe = 0, tgt_start = 0, tgt_din = 0x00, tx_sreg = 0xFF, spi_miso = 1, mcu_irq_n = 1, bit_cnt = byte_cnt = tgt_sel = 0, synchronizers = idle (ss_n 1, sck 0, mosi 0).
REQ-029 Reset asserted mid-frame SHALL abort the frame; a new frame requires an ss_n high-to-low transition after reset release.

Structure
REQ-030 Target ids (SYS=0, HID=1, OSD=2, SDC=3), NUM_TGT=4 and the invalid response 0xFF SHALL live in the shared mcu package.
REQ-031 The synchronizer plus edge detector SHALL be one sub-module, spi_sync_edge, instantiated for sck, ss_n, mosi.

Verification
REQ-032 Frame 0x01,0x01,0x2A -> tgt_strobe[1] twice, first with tgt_start[1]=1 din 0x01, second start=0 din 0x2A; no other target strobed.
REQ-033 tgt_irq=4'b0101 at frame start -> MISO byte 0 = 0x05; mcu_irq_n = 0 within 3 clk of irq rising.
REQ-034 Frame 0x00,0x00,0x00,0x00 with target 0 returning 0x5C then 0x42 -> MISO bytes 1..3 = 0x??,0x5C,0x42 pattern per REQ-024 (byte1 = dout before command).
REQ-035 Frame 0x07,0x01,0x02 -> no tgt_strobe; MISO bytes 1,2 = 0xFF,0xFF.
REQ-036 ss_n raised after 5 bits of byte 2 -> no strobe; next frame 0x01,0x03 produces start strobe to target 1 with din 0x03.
REQ-037 Reset pulsed during byte 1 -> all outputs at REQ-028 values next clk; no strobe until a fresh frame.
